crypto_result_collector: RTL and testbench

Downstream drain stage for the 64-bit crypto accelerator pipeline. It tracks which accelerator pipeline slots carry real operands using a tag shift register that advances in lock-step with the accelerator enable. It captures each valid 64-bit result exactly once into a small FIFO and streams it out as two 32-bit beats on a valid/ready interface. It also raises `hold` so the issuing logic never launches more operands than the FIFO can absorb.

---
 rtl/crypto_result_collector_if.sv | 24 ++
 rtl/crypto_result_collector.sv | 129 ++++++++++++
 tb/tb_crypto_result_collector.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crypto_result_collector_if.sv
// Output stream of the crypto result collector: one 32-bit beat per
// handshake, two beats (low word, then high word) per 64-bit result.
interface crypto_result_collector_if;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;

  // Producer side: the collector drives the beat, the consumer drives ready.
  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  // Consumer side.
  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/crypto_result_collector.sv
// Drain stage for the 64-bit crypto accelerator. A tag shift register that
// moves with the accelerator enable marks which pipeline slots carry real
// operands; each valid result is captured once into a small FIFO and sent
// out as two 32-bit beats. hold keeps upstream from issuing more operands
// than the FIFO can absorb.
module crypto_result_collector #(
  parameter int PIPE_DEPTH = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue,
  input  logic                          advance,
  input  logic [63:0]                   res_data,
  crypto_result_collector_if.master     out_if,
  output logic                          hold,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Wide enough for count + popcount(tag) without wrapping.
  localparam int SW = $clog2(PIPE_DEPTH + FIFO_DEPTH + 1);

  logic [PIPE_DEPTH-1:0] tag;
  logic                  adv_d;
  logic [63:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  beat;
  logic [SW-1:0]         inflight;
  logic [63:0]           head;

  logic empty;
  logic full;
  logic capture;
  logic accept;
  logic pop;
  logic wr_en;
  logic drop;
  logic issue_violation;

  assign empty   = (count == '0);
  assign full    = (count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
  // The result for the oldest tag is on res_data only in the cycle that
  // follows an advancing edge, so a stalled result is captured once.
  assign capture = tag[PIPE_DEPTH-1] & adv_d;
  assign accept  = ~empty & out_if.m_ready;
  assign pop     = accept & beat;
  // A pop on the same edge frees the slot the capture needs.
  assign wr_en   = capture & (~full | pop);
  assign drop    = capture & full & ~pop;
  assign issue_violation = issue & advance & hold;

  // Count operands still inside the accelerator.
  always_comb begin
    // NOTE: default first so every path assigns it and no latch is inferred.
    inflight = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      inflight = inflight + SW'(tag[i]);
    end
  end

  assign hold = (SW'(count) + inflight) >= SW'(FIFO_DEPTH);

  // Tag shift register and registered enable, both moving with the pipeline.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (!rst_n) begin
      tag   <= '0;
      adv_d <= 1'b0;
    end else begin
      adv_d <= advance;
      if (advance) begin
        tag <= {tag[PIPE_DEPTH-2:0], issue};
      end
    end
  end

  // Result storage.
  // NOTE: no reset on the array; count gates every read, so stale words are
  // never visible and the RAM stays reset-free.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= res_data;
    end
  end

  // FIFO pointers, occupancy, beat pointer and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      beat     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept) begin
        beat <= ~beat;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop || issue_violation) begin
        overflow <= 1'b1;
      end
    end
  end

  // Beat framing: low word first, high word marked last; zero when empty.
  always_comb begin
    head           = mem[rd_ptr];
    out_if.m_valid = ~empty;
    out_if.m_last  = ~empty & beat;
    out_if.m_data  = '0;
    if (!empty) begin
      out_if.m_data = beat ? head[63:32] : head[31:0];
    end
  end

endmodule

// File: tb/tb_crypto_result_collector.sv
// Self-checking bench for crypto_result_collector. A queue-based reference
// model tracks issued operands by the advancing edge that sampled them and
// the buffered results as a plain list.
module tb_crypto_result_collector;

  localparam int PD = 9;
  localparam int FD = 4;

  logic        clk;
  logic        rst_n;
  logic        issue;
  logic        advance;
  logic [63:0] res_data;
  logic        hold;
  logic [2:0]  count;
  logic        overflow;

  crypto_result_collector_if bus ();

  crypto_result_collector #(
    .PIPE_DEPTH (PD),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (issue),
    .advance  (advance),
    .res_data (res_data),
    .out_if   (bus),
    .hold     (hold),
    .count    (count),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  logic [63:0] exp_q[$];   // buffered results, head first
  int          iss_q[$];   // advancing-edge number at which each operand was issued
  int          adv_n;      // advancing edges since reset
  bit          prev_adv;
  bit          beat_m;
  bit          ovf_m;

  always @(posedge clk) begin
    bit hold_now, cap_m, full_m, pop_m;
    if (!rst_n) begin
      exp_q.delete();
      iss_q.delete();
      adv_n    = 0;
      prev_adv = 0;
      beat_m   = 0;
      ovf_m    = 0;
    end else begin
      hold_now = (exp_q.size() + iss_q.size()) >= FD;
      // An operand issued on advancing edge a has its result on res_data
      // right after advancing edge a+PD-1.
      cap_m  = prev_adv && iss_q.size() != 0 && iss_q[0] == adv_n - PD + 1;
      full_m = exp_q.size() == FD;
      pop_m  = exp_q.size() != 0 && bus.m_ready && beat_m;
      if (issue && advance && hold_now) ovf_m = 1;
      if (exp_q.size() != 0 && bus.m_ready) begin
        if (beat_m) void'(exp_q.pop_front());
        beat_m = !beat_m;
      end
      if (cap_m) begin
        if (!full_m || pop_m) exp_q.push_back(res_data);
        else ovf_m = 1;
      end
      if (advance) begin
        adv_n++;
        if (issue) iss_q.push_back(adv_n);
        while (iss_q.size() != 0 && iss_q[0] <= adv_n - PD) void'(iss_q.pop_front());
      end
      prev_adv = advance;
    end
  end

  // {m_valid, m_last, m_data, count, hold, overflow}
  logic [38:0] obs;
  assign obs = {bus.m_valid, bus.m_last, bus.m_data, count, hold, overflow};

  function automatic logic [38:0] exp_vec();
    logic        v;
    logic [31:0] d;
    v = exp_q.size() != 0;
    d = 32'h0;
    if (v) d = beat_m ? exp_q[0][63:32] : exp_q[0][31:0];
    return {v, v && beat_m, d, 3'(exp_q.size()),
            (exp_q.size() + iss_q.size()) >= FD, ovf_m};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Drive one cycle of inputs, then wait for the following falling edge.
  task automatic step(input logic i, input logic a, input logic r, input logic [63:0] d);
    issue       = i;
    advance     = a;
    bus.m_ready = r;
    res_data    = d;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 1'b1, 1'b0, rnd64());
    step(1'b0, 1'b0, 1'b0, rnd64());
    n_checks++;
    if (obs === 39'h0) n_pass++;
    else $display("FAIL reset outputs: got %h want 0", obs);
    n_checks++;
    if (obs === exp_vec()) n_pass++;
    else $display("FAIL reset model: got %h want %h", obs, exp_vec());
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    step(1'b1, 1'b1, 1'b0, rnd64());               // edge k
    for (int s = 0; s < PD - 1; s++) begin         // edges k+1 .. k+8
      step(1'b0, 1'b1, 1'b0, rnd64());
      n_checks++;
      if (bus.m_valid === 1'b0 && obs === exp_vec()) n_pass++;
      else $display("FAIL single early valid: got %h want %h", obs, exp_vec());
    end
    step(1'b0, 1'b1, 1'b0, 64'h1122334455667788);  // edge k+9 captures
    n_checks++;
    if ({bus.m_valid, bus.m_last, bus.m_data, count} === {1'b1, 1'b0, 32'h55667788, 3'd1}) n_pass++;
    else $display("FAIL single beat0: got v=%b l=%b d=%h c=%0d want v=1 l=0 d=55667788 c=1",
                  bus.m_valid, bus.m_last, bus.m_data, count);
    step(1'b0, 1'b1, 1'b0, rnd64());               // stalled consumer: must hold
    n_checks++;
    if ({bus.m_valid, bus.m_last, bus.m_data} === {1'b1, 1'b0, 32'h55667788}) n_pass++;
    else $display("FAIL single stable: got v=%b l=%b d=%h want v=1 l=0 d=55667788",
                  bus.m_valid, bus.m_last, bus.m_data);
    step(1'b0, 1'b1, 1'b1, rnd64());
    n_checks++;
    if ({bus.m_valid, bus.m_last, bus.m_data} === {1'b1, 1'b1, 32'h11223344}) n_pass++;
    else $display("FAIL single beat1: got v=%b l=%b d=%h want v=1 l=1 d=11223344",
                  bus.m_valid, bus.m_last, bus.m_data);
    step(1'b0, 1'b1, 1'b1, rnd64());
    n_checks++;
    if (count === 3'd0 && bus.m_valid === 1'b0 && obs === exp_vec()) n_pass++;
    else $display("FAIL single drained: got %h want %h", obs, exp_vec());
  endtask

  task automatic test_stall();
    int beats = 0;
    int peak  = 0;
    logic a;
    for (int s = 0; s < 30; s++) begin
      a = !(s >= PD && s < PD + 5);
      if (bus.m_valid) beats++;
      step(s == 0, a, 1'b1, rnd64());
      if (int'(count) > peak) peak = int'(count);
      n_checks++;
      if (obs === exp_vec()) n_pass++;
      else $display("FAIL stall model: got %h want %h", obs, exp_vec());
    end
    n_checks++;
    if (beats == 2 && peak == 1) n_pass++;
    else $display("FAIL stall counts: got beats=%0d peak=%0d want beats=2 peak=1", beats, peak);
  endtask

  task automatic test_backpressure();
    int issued  = 0;
    int hold_at = 0;
    int beats   = 0;
    logic i;
    for (int s = 0; s < 40; s++) begin
      i = !hold;
      if (i) issued++;
      step(i, 1'b1, 1'b0, rnd64());
      if (hold && hold_at == 0) hold_at = issued;
      n_checks++;
      if (count <= 3'd4 && overflow === 1'b0 && obs === exp_vec()) n_pass++;
      else $display("FAIL backpressure fill: got %h want %h", obs, exp_vec());
    end
    n_checks++;
    if (hold_at == 4 && count === 3'd4) n_pass++;
    else $display("FAIL backpressure hold: got hold_at=%0d count=%0d want 4 and 4", hold_at, count);
    for (int s = 0; s < 12; s++) begin
      if (bus.m_valid) begin
        n_checks++;
        if (bus.m_last === beats[0] && obs === exp_vec()) n_pass++;
        else $display("FAIL backpressure beat %0d: got %h want %h", beats, obs, exp_vec());
        beats++;
      end
      step(1'b0, 1'b1, 1'b1, rnd64());
    end
    n_checks++;
    if (beats == 8 && count === 3'd0) n_pass++;
    else $display("FAIL backpressure drain: got beats=%0d count=%0d want 8 and 0", beats, count);
  endtask

  // Four legal issues fill the budget; a fifth (issued against hold) makes a
  // capture meet a full FIFO on the same edge as a beat-1 pop.
  task automatic test_full_pop();
    logic [63:0] new_entry = '0;
    logic [63:0] d;
    logic [31:0] got[$];
    for (int s = 1; s <= 20; s++) begin
      d = rnd64();
      if (s == 14) new_entry = d;
      step(s <= 5, 1'b1, (s == 13 || s == 14), d);
      if (s == 13 || s == 14) begin
        n_checks++;
        if (count === 3'd4) n_pass++;
        else $display("FAIL full_pop count at step %0d: got %0d want 4", s, count);
      end
      n_checks++;
      if (obs === exp_vec()) n_pass++;
      else $display("FAIL full_pop model: got %h want %h", obs, exp_vec());
    end
    for (int s = 0; s < 12; s++) begin
      if (bus.m_valid) got.push_back(bus.m_data);
      step(1'b0, 1'b1, 1'b1, rnd64());
    end
    n_checks++;
    if (got.size() == 8 && got[6] === new_entry[31:0] && got[7] === new_entry[63:32]) n_pass++;
    else $display("FAIL full_pop last entry: got %0d beats, want 8 ending %h", got.size(), new_entry);
  endtask

  task automatic test_violation();
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, rnd64());
    rst_n = 1'b1;
    for (int s = 0; s < 4; s++) step(1'b1, 1'b1, 1'b0, rnd64());
    for (int s = 0; s < 10; s++) step(1'b0, 1'b1, 1'b0, rnd64());
    n_checks++;
    if (count === 3'd4 && hold === 1'b1 && overflow === 1'b0) n_pass++;
    else $display("FAIL violation pre: got c=%0d h=%b o=%b want 4 1 0", count, hold, overflow);
    step(1'b1, 1'b1, 1'b0, rnd64());
    n_checks++;
    if (overflow === 1'b1 && obs === exp_vec()) n_pass++;
    else $display("FAIL violation edge: got %h want %h", obs, exp_vec());
    for (int s = 0; s < 20; s++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, rnd64());
    n_checks++;
    if (overflow === 1'b1 && count === 3'd4) n_pass++;
    else $display("FAIL violation sticky: got o=%b c=%0d want 1 4", overflow, count);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, rnd64());
    rst_n = 1'b1;
    n_checks++;
    if (overflow === 1'b0) n_pass++;
    else $display("FAIL violation clear: got %b want 0", overflow);
  endtask

  task automatic test_reset_midflight();
    int beats = 0;
    step(1'b1, 1'b1, 1'b0, rnd64());
    step(1'b1, 1'b1, 1'b0, rnd64());
    for (int s = 0; s < PD; s++) step(1'b0, 1'b1, 1'b0, rnd64());
    for (int s = 0; s < 3; s++) step(1'b1, 1'b1, 1'b0, rnd64());
    n_checks++;
    if (count === 3'd2 && obs === exp_vec()) n_pass++;
    else $display("FAIL midflight setup: got %h want %h", obs, exp_vec());
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, rnd64());
    rst_n = 1'b1;
    n_checks++;
    if (count === 3'd0 && bus.m_valid === 1'b0 && hold === 1'b0) n_pass++;
    else $display("FAIL midflight reset: got c=%0d v=%b h=%b want 0 0 0", count, bus.m_valid, hold);
    for (int s = 0; s < 20; s++) begin
      if (bus.m_valid) beats++;
      step(1'b0, 1'b1, 1'b1, rnd64());
    end
    n_checks++;
    if (beats == 0) n_pass++;
    else $display("FAIL midflight ghosts: got %0d beats want 0", beats);
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic        i;
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, rnd64());
    rst_n = 1'b1;
    for (int s = 0; s < 400; s++) begin
      r = $urandom();
      i = (!hold && r[2]) || (r[10:5] == 6'd0);
      step(i, r[0] | r[1], r[3] | r[4], rnd64());
      n_checks++;
      if (obs === exp_vec()) n_pass++;
      else $display("FAIL random cycle %0d: got %h want %h", s, obs, exp_vec());
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    issue       = 1'b0;
    advance     = 1'b0;
    res_data    = '0;
    bus.m_ready = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_backpressure();
    test_full_pop();
    test_violation();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
